iq_stream_iir: RTL and testbench

IQ_STREAM_IIR -- requirements
Module: iq_stream_iir

---
 rtl/vvm_dsp_pkg.sv | 20 ++
 rtl/iir_lane.sv | 37 +++
 rtl/iq_stream_iir.sv | 174 +++++++++++++++++
 tb/tb_iq_stream_iir.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvm_dsp_pkg.sv
// Shared DSP definitions: default word/fraction widths, smoothing FSM states
// and the shift clamp used by the IQ smoothing filter.
package vvm_dsp_pkg;

  localparam int unsigned DW_DEF   = 21;
  localparam int unsigned FRAC_DEF = 16;
  localparam int unsigned SHIFT_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } iir_state_t;

  // Shifts beyond the fraction width would only discard the whole update
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s,
                                                     input int unsigned       frac);
    return (32'(s) > frac) ? SHIFT_W'(frac) : s;
  endfunction

endpackage

// File: rtl/iir_lane.sv
// One-pole smoothing lane: acc <= acc + ((x<<FRAC) - acc) >>> shift.
// Exposes the next-state integer part so the top can publish it on the same edge.
module iir_lane
  import vvm_dsp_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic                clk_adc,
  input  logic                reset,
  input  logic                en,
  input  logic signed [DW-1:0] x,
  input  logic [SHIFT_W-1:0]  shift,
  output logic [DW-1:0]       y_nxt_c
);

  localparam int unsigned AW = DW + FRAC;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt_c;
  logic signed [AW:0]   diff_c;
  logic signed [AW:0]   step_c;

  // The true sum lies between acc and the target, so modular AW-bit addition is exact
  always_comb begin
    diff_c    = $signed({x[DW-1], x, {FRAC{1'b0}}}) - $signed({acc[AW-1], acc});
    step_c    = diff_c >>> shift;
    acc_nxt_c = en ? (acc + AW'(step_c)) : acc;
    y_nxt_c   = acc_nxt_c[AW-1:FRAC];
  end

  always_ff @(posedge clk_adc) begin
    if (!reset) acc <= '0;
    else        acc <= acc_nxt_c;
  end

endmodule

// File: rtl/iq_stream_iir.sv
// Per-channel I/Q smoothing of a serialized CIC frame (I0,Q0,I1,Q1,...).
// Define IQ_STREAM_IIR_SNAPSHOT_EN to publish outputs only on host snap_req.
module iq_stream_iir
  import vvm_dsp_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic                 clk_adc,
  input  logic                 reset,
  input  logic [DW-1:0]        stream_in,
  input  logic                 strobe_in,
  input  logic [SHIFT_W-1:0]   iir_shift,
  input  logic                 err_clr,
  input  logic                 snap_req,
  output logic [N_CH*DW-1:0]   i_out,
  output logic [N_CH*DW-1:0]   q_out,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 snap_ack
);

  localparam int unsigned NW = 2 * N_CH;
  localparam int unsigned IW = (NW > 2) ? $clog2(NW) : 1;

  iir_state_t         state, state_nxt;
  logic [IW-1:0]      idx, idx_nxt;
  logic [SHIFT_W-1:0] shift_q, shift_nxt;
  logic               strobe_q;

  logic               accept_c;
  logic               last_c;
  logic               err_set_c;
  logic [IW-1:0]      word_idx_c;
  logic [SHIFT_W-1:0] cur_shift_c;
  logic [NW-1:0]      lane_en_c;
  logic [DW-1:0]      lane_y_c [NW];
  logic [N_CH*DW-1:0] frame_i_c;
  logic [N_CH*DW-1:0] frame_q_c;

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      shift_q    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shift_q    <= shift_nxt;
      frame_done <= last_c;
      if (err_clr)        frame_err <= 1'b0;
      else if (err_set_c) frame_err <= 1'b1;
    end
  end

  // Edge detector only; it must keep tracking through reset so a stream that is
  // already running when reset lifts is not mistaken for a fresh frame start
  always_ff @(posedge clk_adc) strobe_q <= strobe_in;

  // Framing: word 0 is accepted on the strobe rise, the shift is latched there
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    shift_nxt   = shift_q;
    accept_c    = 1'b0;
    last_c      = 1'b0;
    err_set_c   = 1'b0;
    word_idx_c  = idx;
    cur_shift_c = shift_q;
    case (state)
      IDLE: begin
        if (strobe_in) begin
          if (!strobe_q) begin
            accept_c    = 1'b1;
            word_idx_c  = '0;
            cur_shift_c = clamp_shift(iir_shift, FRAC);
            shift_nxt   = clamp_shift(iir_shift, FRAC);
            idx_nxt     = IW'(1);
            state_nxt   = RUN;
          end else begin
            err_set_c = 1'b1;
          end
        end
      end
      RUN: begin
        if (strobe_in) begin
          accept_c = 1'b1;
          if (idx == IW'(NW - 1)) begin
            last_c    = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          err_set_c = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lane_en_c = '0;
    for (int k = 0; k < int'(NW); k++) begin
      lane_en_c[k] = accept_c && (word_idx_c == IW'(k));
    end
  end

  for (genvar k = 0; k < int'(NW); k++) begin : g_lane
    iir_lane #(
      .DW   (DW),
      .FRAC (FRAC)
    ) u_lane (
      .clk_adc (clk_adc),
      .reset   (reset),
      .en      (lane_en_c[k]),
      .x       (stream_in),
      .shift   (cur_shift_c),
      .y_nxt_c (lane_y_c[k])
    );
  end

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_pack
    assign frame_i_c[c*DW +: DW] = lane_y_c[2*c];
    assign frame_q_c[c*DW +: DW] = lane_y_c[2*c+1];
  end

`ifdef IQ_STREAM_IIR_SNAPSHOT_EN
  logic [N_CH*DW-1:0] shadow_i;
  logic [N_CH*DW-1:0] shadow_q;

  // Completed frames land in the shadow; the host copies all lanes at once
  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      shadow_i <= '0;
      shadow_q <= '0;
      i_out    <= '0;
      q_out    <= '0;
      snap_ack <= 1'b0;
    end else begin
      if (last_c) begin
        shadow_i <= frame_i_c;
        shadow_q <= frame_q_c;
      end
      if (snap_req) begin
        i_out <= shadow_i;
        q_out <= shadow_q;
      end
      snap_ack <= snap_req;
    end
  end
`else
  logic unused_snap_req;
  assign unused_snap_req = snap_req;
  assign snap_ack        = 1'b0;

  always_ff @(posedge clk_adc) begin
    if (!reset) begin
      i_out <= '0;
      q_out <= '0;
    end else if (last_c) begin
      i_out <= frame_i_c;
      q_out <= frame_q_c;
    end
  end
`endif

endmodule

// File: tb/tb_iq_stream_iir.sv
// Directed bench for iq_stream_iir: vector table of pass-through/shift frames
// plus hand sequences for framing errors, shift latching, step response and reset.
module tb_iq_stream_iir;

  localparam int unsigned N_CH = 4;
  localparam int unsigned DW   = 21;
  localparam int unsigned FRAC = 16;
  localparam int unsigned NW   = 2 * N_CH;

  typedef int words_t [NW];
  typedef int lanes_t [N_CH];
  typedef struct {
    int     shift;
    words_t w;
    lanes_t ei;
    lanes_t eq;
  } vec_t;

  logic                 clk_adc = 1'b0;
  logic                 reset = 1'b0;
  logic [DW-1:0]        stream_in = '0;
  logic                 strobe_in = 1'b0;
  logic [5:0]           iir_shift = '0;
  logic                 err_clr = 1'b0;
  logic                 snap_req = 1'b0;
  logic [N_CH*DW-1:0]   i_out;
  logic [N_CH*DW-1:0]   q_out;
  logic                 frame_done;
  logic                 frame_err;
  logic                 snap_ack;

  int n_cmp = 0;
  int n_bad = 0;

  iq_stream_iir #(.N_CH(N_CH), .DW(DW), .FRAC(FRAC)) dut (
    .clk_adc    (clk_adc),
    .reset      (reset),
    .stream_in  (stream_in),
    .strobe_in  (strobe_in),
    .iir_shift  (iir_shift),
    .err_clr    (err_clr),
    .snap_req   (snap_req),
    .i_out      (i_out),
    .q_out      (q_out),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .snap_ack   (snap_ack)
  );

  always #5 clk_adc = ~clk_adc;

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N_CH*DW-1:0] pack(input lanes_t v);
    logic [N_CH*DW-1:0] r;
    r = '0;
    for (int c = 0; c < int'(N_CH); c++) r[c*DW +: DW] = DW'(v[c]);
    return r;
  endfunction

  task automatic snap_if_needed();
`ifdef IQ_STREAM_IIR_SNAPSHOT_EN
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("snap_ack", snap_ack, 1);
`endif
  endtask

  task automatic check_out(input string name, input lanes_t ei, input lanes_t eq);
    snap_if_needed();
    chk({name, "_i"}, i_out, pack(ei));
    chk({name, "_q"}, q_out, pack(eq));
  endtask

  task automatic full_frame(input int sh0, input int sh_rest, input words_t w);
    for (int k = 0; k < int'(NW); k++) begin
      iir_shift = 6'((k == 0) ? sh0 : sh_rest);
      stream_in = DW'(w[k]);
      strobe_in = 1'b1;
      tick();
      if (k == int'(NW) - 2) chk("done_early", frame_done, 0);
    end
    chk("done_pulse", frame_done, 1);
    strobe_in = 1'b0;
    tick();
    chk("done_single", frame_done, 0);
  endtask

  task automatic partial(input int sh, input words_t w, input int n);
    for (int k = 0; k < n; k++) begin
      iir_shift = 6'(sh);
      stream_in = DW'(w[k]);
      strobe_in = 1'b1;
      tick();
    end
  endtask

  task automatic reset_dut();
    strobe_in = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  vec_t   tbl [6];
  words_t w;
  lanes_t ei, eq;
  int     cnt, prev, cur;

  initial begin
    tbl[0].shift = 0;  tbl[0].w = '{1, 2, 3, 4, 5, 6, 7, 8};
    tbl[0].ei = '{1, 3, 5, 7};  tbl[0].eq = '{2, 4, 6, 8};
    tbl[1].shift = 0;  tbl[1].w = '{-1, -2, -3, -4, -5, -6, -7, -8};
    tbl[1].ei = '{-1, -3, -5, -7};  tbl[1].eq = '{-2, -4, -6, -8};
    tbl[2].shift = 1;  tbl[2].w = '{4, 0, 8, -3, -6, 2, 1, -9};
    tbl[2].ei = '{1, 2, -6, -3};  tbl[2].eq = '{-1, -4, -2, -9};
    tbl[3].shift = 0;  tbl[3].w = '{1048575, -1048576, 0, 1, -1, 1048575, -1048576, 0};
    tbl[3].ei = '{1048575, 0, -1, -1048576};  tbl[3].eq = '{-1048576, 1, 1048575, 0};
    tbl[4].shift = 0;  tbl[4].w = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4].ei = '{0, 0, 0, 0};  tbl[4].eq = '{0, 0, 0, 0};
    tbl[5].shift = 40; tbl[5].w = '{65536, 131072, -65536, 655360, 0, 65535, -65537, 196608};
    tbl[5].ei = '{1, -1, 0, -2};  tbl[5].eq = '{2, 10, 0, 3};

    // Reset state
    tick();
    tick();
    chk("rst_i", i_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ack", snap_ack, 0);
    reset = 1'b1;
    tick();

    // Vector table
    for (int v = 0; v < 6; v++) begin
      full_frame(tbl[v].shift, tbl[v].shift, tbl[v].w);
      check_out($sformatf("vec%0d", v), tbl[v].ei, tbl[v].eq);
    end
    chk("err_after_table", frame_err, 0);

    // Strobe drop after 3 words
    w = '{0, 0, 0, 0, 0, 0, 0, 0};
    full_frame(0, 0, w);
    w = '{100, 200, 300, 0, 0, 0, 0, 0};
    partial(0, w, 3);
    strobe_in = 1'b0;
    tick();
    chk("drop_err", frame_err, 1);
    chk("drop_nodone", frame_done, 0);
    tick();
    chk("drop_nodone2", frame_done, 0);
    check_out("drop_hold", '{0, 0, 0, 0}, '{0, 0, 0, 0});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("drop_clr", frame_err, 0);
    w = '{0, 0, 0, 0, 0, 0, 0, 0};
    full_frame(1, 1, w);
    check_out("drop_keep_acc", '{50, 150, 0, 0}, '{100, 0, 0, 0});

    // err_clr wins over a simultaneous drop
    partial(0, w, 2);
    strobe_in = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_prio", frame_err, 0);
    tick();
    chk("clr_prio_hold", frame_err, 0);

    // 10-word burst
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      iir_shift = 6'd0;
      stream_in = DW'(11 + k);
      strobe_in = 1'b1;
      tick();
      cnt += int'(frame_done);
    end
    strobe_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(frame_done);
    end
    chk("burst_done_count", 32'(cnt), 1);
    chk("burst_err", frame_err, 1);
    check_out("burst_out", '{11, 13, 15, 17}, '{12, 14, 16, 18});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("burst_clr", frame_err, 0);
    full_frame(0, 0, tbl[0].w);
    check_out("after_burst", tbl[0].ei, tbl[0].eq);

    // Shift latched on word 0 only
    w = '{21, 22, 23, 24, 25, 26, 27, 28};
    full_frame(0, 16, w);
    check_out("shift_latch0", '{21, 23, 25, 27}, '{22, 24, 26, 28});
    w = '{0, 0, 0, 0, 0, 0, 0, 0};
    full_frame(16, 0, w);
    check_out("shift_latch16", '{20, 22, 24, 26}, '{21, 23, 25, 27});

`ifdef IQ_STREAM_IIR_SNAPSHOT_EN
    // Outputs hold across frames until snap_req
    w = '{5, 6, 7, 8, 9, 10, 11, 12};
    full_frame(0, 0, w);
    tick();
    chk("snap_hold_i", i_out, pack('{20, 22, 24, 26}));
    chk("snap_hold_ack", snap_ack, 0);
    check_out("snap_new", '{5, 7, 9, 11}, '{6, 8, 10, 12});
    tick();
    chk("snap_ack_pulse", snap_ack, 0);
`else
    // snap_req has no effect in the live build
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("nosnap_ack", snap_ack, 0);
    chk("nosnap_i", i_out, pack('{20, 22, 24, 26}));
`endif

    // Step response: I0 = 1000, shift 4
    reset_dut();
    w = '{1000, 0, 0, 0, 0, 0, 0, 0};
    prev = 0;
    for (int f = 0; f < 400; f++) begin
      full_frame(4, 4, w);
      snap_if_needed();
      cur = int'($signed(i_out[DW-1:0]));
      if (f == 0) chk("step_first", 32'(cur), 62);
      chk("step_monotonic", (cur >= prev), 1);
      prev = cur;
    end
    chk("step_final", 32'(cur), 999);

    // Reset mid-frame
    w = '{500, 500, 500, 500, 0, 0, 0, 0};
    partial(0, w, 3);
    stream_in = DW'(500);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    strobe_in = 1'b0;
    tick();
    chk("midrst_err", frame_err, 0);
    chk("midrst_done", frame_done, 0);
    check_out("midrst_out", '{0, 0, 0, 0}, '{0, 0, 0, 0});
    w = '{2, 2, 2, 2, 2, 2, 2, 2};
    full_frame(1, 1, w);
    check_out("midrst_acc_zero", '{1, 1, 1, 1}, '{1, 1, 1, 1});
    chk("midrst_err_end", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
